// File: rtl/note_player_pkg.sv
// Shared widths, rest encoding and player FSM state encoding for the song reader / note player.
package note_player_pkg;

    localparam int unsigned NoteW  = 6;
    localparam int unsigned DurW   = 6;
    localparam int unsigned PhaseW = 20;

    localparam logic [NoteW-1:0] RestNote = '0;

    typedef enum logic [1:0] {
        PlayerIdle    = 2'd0,
        PlayerPlaying = 2'd1,
        PlayerPaused  = 2'd2,
        PlayerDone    = 2'd3
    } player_state_e;

endpackage

// File: rtl/note_player_if.sv
// Note interface between the song reader (master) and the note player (slave).
interface note_player_if;
    import note_player_pkg::*;

    logic              play;
    logic              beat;
    logic              sample_tick;
    logic              new_note;
    logic [NoteW-1:0]  note;
    logic [DurW-1:0]   duration;
    logic              note_done;
    logic              active;
    logic [PhaseW-1:0] phase;

    modport master (
        output play, beat, sample_tick, new_note, note, duration,
        input  note_done, active, phase
    );

    modport slave (
        input  play, beat, sample_tick, new_note, note, duration,
        output note_done, active, phase
    );

endinterface

// File: rtl/note_step_lut.sv
// Combinational note index -> phase step table (48 kHz sample rate, 2^20 phase per cycle).
module note_step_lut
    import note_player_pkg::*;
(
    input  logic [NoteW-1:0]  note_i,
    output logic [PhaseW-1:0] step_o
);

    logic [NoteW-1:0] key;
    logic [2:0]       octave;
    logic [3:0]       semi;
    logic [10:0]      base;

    // Note 1 is A0; each octave up doubles the lowest-octave step.
    always_comb begin
        key    = note_i - NoteW'(1);
        octave = 3'(key / NoteW'(12));
        semi   = 4'(key % NoteW'(12));
        case (semi)
            4'd0:    base = 11'd601;
            4'd1:    base = 11'd636;
            4'd2:    base = 11'd674;
            4'd3:    base = 11'd714;
            4'd4:    base = 11'd757;
            4'd5:    base = 11'd802;
            4'd6:    base = 11'd850;
            4'd7:    base = 11'd900;
            4'd8:    base = 11'd954;
            4'd9:    base = 11'd1010;
            4'd10:   base = 11'd1070;
            4'd11:   base = 11'd1134;
            default: base = '0;
        endcase
        step_o = (note_i == RestNote) ? '0 : (PhaseW'(base) << octave);
    end

endmodule

// File: rtl/note_player.sv
// Note player: latches a note, advances a phase accumulator on sample ticks, counts beats and
// pulses note_done when the duration expires.
module note_player
    import note_player_pkg::*;
(
    input logic             clk,
    input logic             reset_n,
    note_player_if.slave    bus
);

    player_state_e     state_q, state_d;
    logic [NoteW-1:0]  note_q, note_d;
    logic [DurW-1:0]   dur_q, dur_d;
    logic [DurW-1:0]   count_q, count_d;
    logic [PhaseW-1:0] step_q, step_d;
    logic [PhaseW-1:0] phase_q, phase_d;
    logic              active_q, active_d;
    logic              done_q, done_d;

    logic [PhaseW-1:0] lut_step;
    logic [DurW-1:0]   count_inc;
    logic              load;

    note_step_lut u_step_lut (
        .note_i (bus.note),
        .step_o (lut_step)
    );

    assign count_inc = count_q + DurW'(1);
    assign load      = bus.new_note && bus.play;

    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        dur_d   = dur_q;
        count_d = count_q;
        step_d  = step_q;
        phase_d = phase_q;

        if (load) begin
            note_d  = bus.note;
            dur_d   = bus.duration;
            count_d = '0;
            phase_d = '0;
            step_d  = lut_step;
            state_d = (bus.duration == '0) ? PlayerDone : PlayerPlaying;
        end else begin
            unique case (state_q)
                PlayerIdle: ;
                PlayerPlaying: begin
                    if (!bus.play) begin
                        state_d = PlayerPaused;
                    end else begin
                        if (bus.beat) begin
                            count_d = count_inc;
                            if (count_inc == dur_q) state_d = PlayerDone;
                        end
                        if (bus.sample_tick) phase_d = phase_q + step_q;
                    end
                end
                PlayerPaused: begin
                    if (bus.play) state_d = PlayerPlaying;
                end
                PlayerDone: state_d = PlayerIdle;
                default:    state_d = PlayerIdle;
            endcase
        end

        active_d = (state_d == PlayerPlaying) && (note_d != RestNote);
        // Back-to-back zero-length notes would otherwise give adjacent pulses.
        done_d   = (state_q == PlayerDone) && !done_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= PlayerIdle;
            note_q   <= '0;
            dur_q    <= '0;
            count_q  <= '0;
            step_q   <= '0;
            phase_q  <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            note_q   <= note_d;
            dur_q    <= dur_d;
            count_q  <= count_d;
            step_q   <= step_d;
            phase_q  <= phase_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign bus.note_done = done_q;
    assign bus.active    = active_q;
    assign bus.phase     = phase_q;

endmodule
